// File: rtl/compare_sequencer_if.sv
// Bundle between the compare sequencer, its requester, its responder and the comparator.
// The master side is the sequencer; the slave side is the surrounding ALU control path.
interface compare_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic [3:0]       cmp_opcode;
  logic [3:0]       cmp_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [3:0]       rsp_flags;
  logic             rsp_error;

  modport master (
    input  req_valid, req_a, req_b, cmp_result, rsp_ready,
    output req_ready, cmp_a, cmp_b, cmp_opcode, rsp_valid, rsp_flags, rsp_error
  );

  modport slave (
    output req_valid, req_a, req_b, cmp_result, rsp_ready,
    input  req_ready, cmp_a, cmp_b, cmp_opcode, rsp_valid, rsp_flags, rsp_error
  );
endinterface

// File: rtl/compare_sequencer.sv
// Drives the four compare opcodes for one (A,B) pair through the comparator and
// returns {lt,gt,ne,eq} plus a sanity error bit.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | leaving reset, not yet accepting requests
// IDLE  | req_ready=1, waiting for an operand pair
// ISSUE | one opcode per cycle, collecting cmp_result[0] into flags
// RESP  | rsp_valid=1, flags/error held until the consumer takes them
module compare_sequencer #(
  parameter int         WIDTH   = 4,
  parameter logic [3:0] OP_BASE = 4'b1100,
  parameter logic [3:0] OP_IDLE = 4'b0000
) (
  input logic               clk,
  input logic               rst_n,
  compare_sequencer_if.master bus
);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       step;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       op_q;
  logic [3:0]       flags_q;
  logic             err_q;

  logic [3:0]       flags_nxt;
  logic             err_nxt;
  logic             final_bad;
  logic [1:0]       one_hot_sum;

  // Flags as they will look after this sample; the end-of-sequence checks
  // must see the LT bit being written on the last ISSUE edge.
  always_comb begin
    flags_nxt       = flags_q;
    flags_nxt[step] = bus.cmp_result[0];
    err_nxt         = err_q | (bus.cmp_result[3:1] != 3'b000);
    one_hot_sum     = {1'b0, flags_nxt[0]} + {1'b0, flags_nxt[2]} + {1'b0, flags_nxt[3]};
    final_bad       = ((flags_nxt[0] ^ flags_nxt[1]) != 1'b1) || (one_hot_sum != 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      step    <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_IDLE;
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
    end else begin
      case (state)
        S_INIT: state <= S_IDLE;
        S_IDLE: begin
          if (bus.req_valid) begin
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            flags_q <= 4'b0000;
            err_q   <= 1'b0;
            step    <= 2'd0;
            op_q    <= OP_BASE;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          flags_q <= flags_nxt;
          if (step == 2'd3) begin
            op_q  <= OP_IDLE;
            err_q <= err_nxt | final_bad;
            state <= S_RESP;
          end else begin
            step  <= step + 2'd1;
            op_q  <= op_q + 4'd1;
            err_q <= err_nxt;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.rsp_valid  = (state == S_RESP);
  assign bus.cmp_a      = a_q;
  assign bus.cmp_b      = b_q;
  assign bus.cmp_opcode = op_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_error  = err_q;

endmodule
